// File: rtl/fetch_pkg.sv
// Shared types and defaults for the prefetching fetch stage.
// A queue entry carries an instruction together with the PC it was fetched from.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP                = '0;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus plus the decode-side handshake.
// The master modport is the fetch unit's view; slave is the memory/decode side.
interface fetch_prefetch_unit_if #(
   parameter int XLEN = fetch_pkg::XLEN
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] inst_out;

   modport master (
      output imem_req, imem_addr, if_valid, pc_out, inst_out,
      input  imem_gnt, imem_rvalid, imem_rdata, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, pc_out, inst_out,
      output imem_gnt, imem_rvalid, imem_rdata, if_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Show-ahead FIFO of fetched {pc, inst} entries; the head is readable combinationally.
// Flush wins over push; push and pop may coincide even when full.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == (AW+1)'(DEPTH));
   assign push_ok   = push && (!full || pop);
   assign pop_ok    = pop && !empty;
   assign occupancy = count_reg;
   assign head      = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   // Storage has no reset: entries are only visible once counted in.
   always_ff @(posedge clk) begin
      if (push_ok && !flush && !rst) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching IF stage: pipelined requests to a variable-latency instruction memory,
// buffered results to decode, and redirect handling that kills in-flight responses.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN            = fetch_pkg::XLEN,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] EXC_VECTOR      = DEFAULT_EXC_VECTOR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  br,
   input  logic [XLEN-1:0]       pc_branch,
   input  logic                  except,
   fetch_prefetch_unit_if.master bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;

   logic [XLEN-1:0] fpc_reg;
   logic [XLEN-1:0] rpc_reg;
   logic [OW-1:0]   outstanding_reg;
   logic [OW-1:0]   outstanding_next;
   logic [OW-1:0]   kill_reg;
   logic [OW-1:0]   kill_next;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic [SW-1:0]   reserved;
   logic            gnt_fire;
   logic            q_push;
   logic            q_pop;
   logic            q_empty;
   logic            q_full;
   logic [CW-1:0]   q_occupancy;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_data;

   assign redirect = except | br;
   assign target   = except ? EXC_VECTOR : pc_branch;

   // Queue slots are reserved at grant time, so a returning response always has room.
   assign reserved     = SW'(q_occupancy) + SW'(outstanding_reg);
   assign bus.imem_req = !rst && !redirect
                         && (reserved < SW'(DEPTH))
                         && (outstanding_reg < OW'(MAX_OUTSTANDING));
   assign bus.imem_addr = fpc_reg;
   assign gnt_fire      = bus.imem_req && bus.imem_gnt;

   assign q_push      = bus.imem_rvalid && (kill_reg == '0) && !redirect;
   assign q_push_data = '{pc: rpc_reg, inst: bus.imem_rdata};
   assign q_pop       = bus.if_valid && bus.if_ready;

   assign outstanding_next = outstanding_reg + OW'(gnt_fire) - OW'(bus.imem_rvalid);

   always_comb begin
      kill_next = kill_reg;
      if (redirect)
         kill_next = outstanding_next;
      else if (bus.imem_rvalid && (kill_reg != '0))
         kill_next = kill_reg - OW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_reg         <= RESET_PC;
         rpc_reg         <= RESET_PC;
         outstanding_reg <= '0;
         kill_reg        <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         kill_reg        <= kill_next;
         if (redirect) begin
            fpc_reg <= target;
            rpc_reg <= target;
         end else begin
            if (gnt_fire) fpc_reg <= fpc_reg + XLEN'(4);
            if (q_push)   rpc_reg <= rpc_reg + XLEN'(4);
         end
      end
   end

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect),
      .head      (q_head),
      .occupancy (q_occupancy),
      .empty     (q_empty),
      .full      (q_full)
   );

   assign bus.if_valid = !rst && !q_empty && !redirect;
   assign bus.pc_out   = q_empty ? NOP : q_head.pc;
   assign bus.inst_out = q_empty ? NOP : q_head.inst;

   a_rvalid_needs_request: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rvalid |-> (outstanding_reg != '0));

   a_push_has_room: assert property (@(posedge clk) disable iff (rst)
      q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: a cycle table for stream/back-pressure/branch timing,
// hand sequences for redirect corner cases, and a grant-ordered scoreboard throughout.
module tb_fetch_prefetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br = 1'b0;
   logic        except = 1'b0;
   logic [31:0] pc_branch = '0;

   always #5 clk = ~clk;

   fetch_prefetch_unit_if #(.XLEN(32)) bus();

   fetch_prefetch_unit #(
      .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2),
      .RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h8000_0180)
   ) dut (
      .clk(clk), .rst(rst), .br(br), .pc_branch(pc_branch), .except(except), .bus(bus)
   );

   typedef struct { logic [31:0] addr; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   typedef struct {
      logic ready; logic brv; logic [31:0] tgt;
      logic req; logic [31:0] addr; logic valid; logic [31:0] pc; logic [31:0] inst;
   } vec_t;

   req_t        pend[$];
   exp_t        sb[$];
   vec_t        tv[17];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   bit          rand_lat = 1'b0;
   int          pops = 0;
   logic [31:0] last_pop_pc = '0;
   logic [31:0] last_gnt_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sample just before the edge, advance one cycle, then drive the memory response.
   task automatic tick();
      exp_t e;
      int   l;
      #2;
      if (rst) begin
         sb.delete();
         pend.delete();
      end else begin
         if (bus.if_valid && bus.if_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h, expected no entry", bus.pc_out);
            end else begin
               e = sb.pop_front();
               check("sb_pc", bus.pc_out, e.pc);
               check("sb_inst", bus.inst_out, e.inst);
               last_pop_pc = bus.pc_out;
               pops++;
               $display("pop pc=%h inst=%h cycle=%0d", bus.pc_out, bus.inst_out, cyc);
            end
         end
         if (bus.imem_rvalid && pend.size() > 0) void'(pend.pop_front());
         if (br || except) sb.delete();
         if (bus.imem_req && bus.imem_gnt) begin
            l = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            pend.push_back('{bus.imem_addr, cyc + l});
            sb.push_back('{bus.imem_addr, bus.imem_addr | 32'hA000_0000});
            last_gnt_addr = bus.imem_addr;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = pend[0].addr | 32'hA000_0000;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 32'hDEAD_BEEF;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; br = 1'b0; except = 1'b0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic wait_first_pop(input string name, input logic [31:0] exp_pc);
      int p0;
      p0 = pops;
      for (int k = 0; k < 20 && pops == p0; k++) tick();
      check({name, "_arrived"}, 32'(pops > p0), 32'd1);
      check({name, "_pc"}, last_pop_pc, exp_pc);
   endtask

   initial begin
      logic [31:0] hold_addr;

      //              rdy br tgt        req addr          vld pc           inst
      tv[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0,   32'h0};
      tv[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h0,   32'h0};
      tv[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h0,   32'hA000_0000};
      tv[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h0,   32'hA000_0000};
      tv[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'hA000_0000};
      tv[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'hA000_0000};
      tv[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h0,   32'hA000_0000};
      tv[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h04,  32'hA000_0004};
      tv[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h08,  32'hA000_0008};
      tv[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h0C,  32'hA000_000C};
      tv[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10,  32'hA000_0010};
      tv[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h14,  32'hA000_0014};
      tv[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h24,  1'b1, 32'h18,  32'hA000_0018};
      tv[13] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h28,  1'b0, 32'h1C,  32'hA000_001C};
      tv[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
      tv[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
      tv[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 32'hA000_0100};

      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.if_ready    = 1'b0;
      @(negedge clk);

      // Reset held three cycles; outputs must stay quiet.
      repeat (2) tick();
      #1;
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_valid", 32'(bus.if_valid), 32'd0);
      tick();
      rst = 1'b0;

      // 1-cycle memory: back-pressure fill, release, streaming, then a branch.
      mem_lat = 1;
      for (int i = 0; i < 17; i++) begin
         bus.if_ready = tv[i].ready;
         bus.imem_gnt = 1'b1;
         br           = tv[i].brv;
         pc_branch    = tv[i].tgt;
         #1;
         check($sformatf("tv%0d_req", i),  32'(bus.imem_req), 32'(tv[i].req));
         check($sformatf("tv%0d_addr", i), bus.imem_addr,     tv[i].addr);
         check($sformatf("tv%0d_valid", i), 32'(bus.if_valid), 32'(tv[i].valid));
         check($sformatf("tv%0d_pc", i),   bus.pc_out,        tv[i].pc);
         check($sformatf("tv%0d_inst", i), bus.inst_out,      tv[i].inst);
         tick();
      end
      br = 1'b0;

      // Branch with two requests in flight on a 2-cycle memory.
      mem_lat = 2; bus.if_ready = 1'b1; bus.imem_gnt = 1'b1;
      do_reset(2);
      tick(); tick();
      br = 1'b1; pc_branch = 32'h100;
      #1;
      check("brA_req_in_redirect", 32'(bus.imem_req), 32'd0);
      check("brA_valid_in_redirect", 32'(bus.if_valid), 32'd0);
      tick();
      br = 1'b0;
      #1;
      check("brA_next_addr", bus.imem_addr, 32'h100);
      check("brA_next_req", 32'(bus.imem_req), 32'd1);
      check("brA_queue_empty", 32'(bus.if_valid), 32'd0);
      wait_first_pop("brA_first", 32'h100);

      // Exception beats a simultaneous branch.
      do_reset(2);
      tick(); tick();
      br = 1'b1; except = 1'b1; pc_branch = 32'h200;
      #1;
      check("exc_valid_in_redirect", 32'(bus.if_valid), 32'd0);
      check("exc_req_in_redirect", 32'(bus.imem_req), 32'd0);
      tick();
      br = 1'b0; except = 1'b0;
      #1;
      check("exc_next_addr", bus.imem_addr, 32'h8000_0180);
      wait_first_pop("exc_first", 32'h8000_0180);

      // Back-to-back branches on a 3-cycle memory: the second target wins.
      mem_lat = 3;
      do_reset(2);
      tick(); tick();
      br = 1'b1; pc_branch = 32'h300;
      tick();
      pc_branch = 32'h400;
      tick();
      br = 1'b0;
      #1;
      check("b2b_next_addr", bus.imem_addr, 32'h400);
      wait_first_pop("b2b_first", 32'h400);

      // Grant stalled for five cycles: address and request held.
      mem_lat = 1;
      do_reset(1);
      repeat (6) tick();
      bus.imem_gnt = 1'b0;
      hold_addr = last_gnt_addr + 32'd4;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("stall_req", 32'(bus.imem_req), 32'd1);
         check("stall_addr", bus.imem_addr, hold_addr);
         tick();
      end
      bus.imem_gnt = 1'b1;
      repeat (10) tick();

      // Reset asserted mid-stream.
      rst = 1'b1;
      #1;
      check("midrst_req", 32'(bus.imem_req), 32'd0);
      check("midrst_valid", 32'(bus.if_valid), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_addr", bus.imem_addr, 32'h0);
      check("midrst_valid_after", 32'(bus.if_valid), 32'd0);
      check("midrst_pc_after", bus.pc_out, 32'h0);
      check("midrst_req_after", 32'(bus.imem_req), 32'd1);
      repeat (10) tick();

      // Random grants, back-pressure, latencies and redirects.
      rand_lat = 1'b1;
      for (int k = 0; k < 300; k++) begin
         bus.imem_gnt = ($urandom_range(0, 3) != 0);
         bus.if_ready = ($urandom_range(0, 3) != 0);
         br           = ($urandom_range(0, 19) == 0);
         except       = ($urandom_range(0, 39) == 0);
         pc_branch    = 32'($urandom_range(0, 1023)) << 2;
         tick();
      end
      br = 1'b0; except = 1'b0; bus.imem_gnt = 1'b0; bus.if_ready = 1'b1;
      for (int k = 0; k < 30 && sb.size() > 0; k++) tick();
      check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
